// File: rtl/flash_dma_pkg.sv
// Shared encodings for the flash-to-memory block copy engine: FSM states,
// CPU register map, CTRL/STATUS bits and the spi_flash register map.
package flash_dma_pkg;

  typedef enum logic [3:0] {
    IDLE, WAKE_CMD, WAKE_SETTLE, WAKE_POLL, SET_LO, SET_HI, GO,
    SETTLE, POLL, READ, MEM_WR, NEXT, FINISH
  } state_t;

  localparam int REG_FL_LO    = 0;
  localparam int REG_FL_HI    = 1;
  localparam int REG_MEM_ADDR = 2;
  localparam int REG_COUNT    = 3;
  localparam int REG_CTRL     = 4;
  localparam int REG_STATUS   = 5;

  localparam int CTRL_START    = 0;
  localparam int CTRL_WAKE     = 1;
  localparam int CTRL_CLR_DONE = 2;
  localparam int CTRL_ABORT    = 3;
  localparam int CTRL_IRQ_EN   = 4;

  localparam int FL_REG_ADDR_LO = 0;
  localparam int FL_REG_ADDR_HI = 1;
  localparam int FL_REG_CMD     = 2;
  localparam int FL_REG_DATA    = 3;
  localparam int FL_REG_STATUS  = 4;

  localparam int FL_CMD_READ = 0;
  localparam int FL_CMD_WAKE = 1;
  localparam int FL_STAT_DONE = 0;

  localparam int FL_ADDR_W = 23;
  localparam int FL_HI_W   = FL_ADDR_W - 16;

  localparam int SETTLE_LEN = 3;

endpackage

// File: rtl/flash_dma_regs.sv
// CPU-visible register file: working address/count registers, CTRL decode,
// STATUS read mux and the busy lock that freezes the working registers.
module flash_dma_regs
  import flash_dma_pkg::*;
#(
  parameter int BITS          = 16,
  parameter int ADDRESS_BITS  = 8,
  parameter int MEM_ADDR_BITS = 16
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic [ADDRESS_BITS-1:0]  address,
  input  logic [BITS-1:0]          data_in,
  input  logic                     wr,
  input  logic                     advance,
  input  logic                     finish,
  output logic [BITS-1:0]          data_out,
  output logic                     start,
  output logic                     wake,
  output logic                     busy,
  output logic                     abort_pend,
  output logic                     irq,
  output logic [FL_ADDR_W-1:0]     fl_addr,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic                     count_zero,
  output logic                     last_word
);

  logic [BITS-1:0] count;
  logic            done;
  logic            aborted;
  logic            irq_en;
  logic            ctrl_wr;

  assign ctrl_wr    = wr && (address == ADDRESS_BITS'(REG_CTRL));
  assign start      = ctrl_wr && data_in[CTRL_START] && !busy;
  assign wake       = data_in[CTRL_WAKE];
  assign irq        = done & irq_en;
  assign count_zero = (count == '0);
  assign last_word  = (count == BITS'(1));

  always_ff @(posedge clk) begin
    if (!rstb) begin
      fl_addr    <= '0;
      mem_addr   <= '0;
      count      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      abort_pend <= 1'b0;
      irq_en     <= 1'b0;
    end else begin
      if (advance) begin
        fl_addr  <= fl_addr + FL_ADDR_W'(1);
        mem_addr <= mem_addr + MEM_ADDR_BITS'(1);
        count    <= count - BITS'(1);
      end else if (wr && !busy) begin
        case (address)
          ADDRESS_BITS'(REG_FL_LO):    fl_addr[15:0] <= data_in[15:0];
          ADDRESS_BITS'(REG_FL_HI):    fl_addr[FL_ADDR_W-1:16] <= data_in[FL_HI_W-1:0];
          ADDRESS_BITS'(REG_MEM_ADDR): mem_addr <= MEM_ADDR_BITS'(data_in);
          ADDRESS_BITS'(REG_COUNT):    count <= data_in;
          default: ;
        endcase
      end
      if (ctrl_wr) begin
        irq_en <= data_in[CTRL_IRQ_EN];
        if (start) begin
          busy       <= 1'b1;
          done       <= 1'b0;
          aborted    <= 1'b0;
          abort_pend <= 1'b0;
        end else begin
          if (data_in[CTRL_ABORT] && busy) abort_pend <= 1'b1;
          if (data_in[CTRL_CLR_DONE] && !busy) done <= 1'b0;
        end
      end
      // An abort arriving in the FINISH cycle itself is dropped.
      if (finish) begin
        busy       <= 1'b0;
        done       <= 1'b1;
        aborted    <= abort_pend;
        abort_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    data_out = '0;
    case (address)
      ADDRESS_BITS'(REG_FL_LO):    data_out = BITS'(fl_addr[15:0]);
      ADDRESS_BITS'(REG_FL_HI):    data_out = BITS'(fl_addr[FL_ADDR_W-1:16]);
      ADDRESS_BITS'(REG_MEM_ADDR): data_out = BITS'(mem_addr);
      ADDRESS_BITS'(REG_COUNT):    data_out = count;
      ADDRESS_BITS'(REG_STATUS):   data_out = BITS'({irq_en, aborted, done, busy});
      default: ;
    endcase
  end

endmodule

// File: rtl/flash_dma.sv
// Block-copy engine: reads consecutive 16-bit words through the spi_flash
// register port and writes them to memory over a req/ack write port.
module flash_dma
  import flash_dma_pkg::*;
#(
  parameter int BITS          = 16,
  parameter int ADDRESS_BITS  = 8,
  parameter int MEM_ADDR_BITS = 16
) (
  input  logic                     CLK,
  input  logic                     RSTb,
  input  logic [ADDRESS_BITS-1:0]  ADDRESS,
  input  logic [BITS-1:0]          DATA_IN,
  output logic [BITS-1:0]          DATA_OUT,
  input  logic                     WR,
  output logic [ADDRESS_BITS-1:0]  FL_ADDRESS,
  output logic [BITS-1:0]          FL_DATA_IN,
  output logic                     FL_WR,
  input  logic [BITS-1:0]          FL_DATA_OUT,
  output logic [MEM_ADDR_BITS-1:0] M_ADDR,
  output logic [BITS-1:0]          M_DATA,
  output logic                     M_REQ,
  input  logic                     M_ACK,
  output logic                     IRQ
);

  state_t                   state, state_nxt;
  logic [1:0]               settle_cnt;
  logic                     settling, settle_done;
  logic [BITS-1:0]          rd_data;
  logic                     start, wake, busy, abort_pend;
  logic                     advance, finish, count_zero, last_word;
  logic [FL_ADDR_W-1:0]     fl_addr;
  logic [MEM_ADDR_BITS-1:0] mem_addr;

  flash_dma_regs #(
    .BITS(BITS), .ADDRESS_BITS(ADDRESS_BITS), .MEM_ADDR_BITS(MEM_ADDR_BITS)
  ) u_regs (
    .clk(CLK), .rstb(RSTb), .address(ADDRESS), .data_in(DATA_IN), .wr(WR),
    .advance(advance), .finish(finish), .data_out(DATA_OUT), .start(start),
    .wake(wake), .busy(busy), .abort_pend(abort_pend), .irq(IRQ),
    .fl_addr(fl_addr), .mem_addr(mem_addr), .count_zero(count_zero),
    .last_word(last_word)
  );

  assign settling    = (state == WAKE_SETTLE) || (state == SETTLE);
  assign settle_done = (settle_cnt == 2'(SETTLE_LEN - 1));
  assign M_ADDR      = mem_addr;
  assign M_DATA      = rd_data;

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state      <= IDLE;
      settle_cnt <= '0;
      rd_data    <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= (settling && !settle_done) ? settle_cnt + 2'd1 : 2'd0;
      if (state == READ) rd_data <= FL_DATA_OUT;
    end
  end

  always_comb begin
    state_nxt  = state;
    FL_WR      = 1'b0;
    FL_ADDRESS = ADDRESS_BITS'(FL_REG_STATUS);
    FL_DATA_IN = '0;
    M_REQ      = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE:
        if (start) state_nxt = wake ? WAKE_CMD : (count_zero ? FINISH : SET_LO);
      WAKE_CMD: begin
        FL_WR                   = 1'b1;
        FL_ADDRESS              = ADDRESS_BITS'(FL_REG_CMD);
        FL_DATA_IN[FL_CMD_WAKE] = 1'b1;
        state_nxt               = WAKE_SETTLE;
      end
      WAKE_SETTLE:
        if (settle_done) state_nxt = WAKE_POLL;
      WAKE_POLL:
        if (FL_DATA_OUT[FL_STAT_DONE]) state_nxt = count_zero ? FINISH : SET_LO;
      SET_LO: begin
        FL_WR      = 1'b1;
        FL_ADDRESS = ADDRESS_BITS'(FL_REG_ADDR_LO);
        FL_DATA_IN = BITS'(fl_addr[15:0]);
        state_nxt  = SET_HI;
      end
      SET_HI: begin
        FL_WR      = 1'b1;
        FL_ADDRESS = ADDRESS_BITS'(FL_REG_ADDR_HI);
        FL_DATA_IN = BITS'(fl_addr[FL_ADDR_W-1:16]);
        state_nxt  = GO;
      end
      GO: begin
        FL_WR                   = 1'b1;
        FL_ADDRESS              = ADDRESS_BITS'(FL_REG_CMD);
        FL_DATA_IN[FL_CMD_READ] = 1'b1;
        state_nxt               = SETTLE;
      end
      // The settle wait keeps the previous command's done bit from being seen.
      SETTLE:
        if (settle_done) state_nxt = POLL;
      POLL:
        if (FL_DATA_OUT[FL_STAT_DONE]) state_nxt = READ;
      READ: begin
        FL_ADDRESS = ADDRESS_BITS'(FL_REG_DATA);
        state_nxt  = MEM_WR;
      end
      MEM_WR: begin
        M_REQ = 1'b1;
        if (M_ACK) state_nxt = NEXT;
      end
      NEXT: begin
        advance   = 1'b1;
        state_nxt = (last_word || abort_pend) ? FINISH : SET_LO;
      end
      FINISH: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
